// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the mips debug/loader path:
// UART command bytes and the loader FSM states.
package mips_dbg_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_STEP = 8'h53;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CNT,
    S_LOAD_DATA,
    S_RUN,
    S_STEP
  } ld_state_e;

endpackage

// File: rtl/word_packer.sv
// MSB-first byte-to-word packer; done_o flags the byte
// that completes a word, with word_o valid in that cycle.
module word_packer #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [7:0]      byte_i,
  output logic [SIZE-1:0] word_o,
  output logic            done_o
);

  localparam int NB = SIZE / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  if (NB > 1) begin : g_multi
    localparam logic [BW-1:0] LAST = BW'(NB - 1);

    logic [SIZE-9:0] sh_q, sh_d;
    logic [BW-1:0]   cnt_q, cnt_d;

    assign word_o = {sh_q, byte_i};
    assign done_o = en && (cnt_q == LAST);

    always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (en) begin
        sh_d  = (SIZE-8)'({sh_q, byte_i});
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q  <= '0;
        cnt_q <= '0;
      end else begin
        sh_q  <= sh_d;
        cnt_q <= cnt_d;
      end
    end
  end else begin : g_single
    assign word_o = byte_i;
    assign done_o = en;
  end

endmodule

// File: rtl/instr_loader.sv
// UART-driven program loader and run/halt/step
// controller feeding the mips core's imem, stall and reset.
module instr_loader
  import mips_dbg_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]   o_imem_data,
  output logic              o_stall,
  output logic              o_cpu_rst,
  output logic              o_loaded
);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic              stall_q, stall_d;
  logic              crst_q, crst_d;
  logic              loaded_q, loaded_d;

  logic            pk_en, pk_clr, pk_done;
  logic [SIZE-1:0] pk_word;
  logic            is_load, is_run, is_halt, is_step;

  assign pk_en   = i_rx_valid && (state_q == S_LOAD_DATA);
  assign pk_clr  = i_rx_valid && (state_q == S_LOAD_CNT);
  assign is_load = i_rx_valid && (i_rx_data == CMD_LOAD);
  assign is_run  = i_rx_valid && (i_rx_data == CMD_RUN);
  assign is_halt = i_rx_valid && (i_rx_data == CMD_HALT);
  assign is_step = i_rx_valid && (i_rx_data == CMD_STEP);

  word_packer #(.SIZE(SIZE)) u_pack (
    .clk    (clk),
    .rst    (rst),
    .clr    (pk_clr),
    .en     (pk_en),
    .byte_i (i_rx_data),
    .word_o (pk_word),
    .done_o (pk_done)
  );

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    n_d      = n_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    crst_d   = crst_q;
    loaded_d = loaded_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_load: begin
            state_d  = S_LOAD_CNT;
            crst_d   = 1'b1;
            loaded_d = 1'b0;
          end
          is_run: begin
            state_d = S_RUN;
            crst_d  = 1'b0;
          end
          is_step: begin
            state_d = S_STEP;
            crst_d  = 1'b0;
          end
          default: ;
        endcase
      end
      S_LOAD_CNT: begin
        if (i_rx_valid) begin
          n_d     = ADDR_W'(i_rx_data);
          wc_d    = '0;
          state_d = S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        if (pk_done) begin
          we_d   = 1'b1;
          addr_d = wc_q;
          data_d = pk_word;
          wc_d   = wc_q + A_ONE;
          // n_q == 0 lands on all-ones: a full 2^ADDR_W load
          if (wc_q == n_q - A_ONE) begin
            loaded_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_RUN: begin
        unique case (1'b1)
          is_halt: state_d = S_IDLE;
          is_load: begin
            state_d  = S_LOAD_CNT;
            crst_d   = 1'b1;
            loaded_d = 1'b0;
          end
          default: ;
        endcase
      end
      S_STEP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    stall_d = !((state_d == S_RUN) || (state_d == S_STEP));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wc_q     <= '0;
      n_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      stall_q  <= 1'b1;
      crst_q   <= 1'b1;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      n_q      <= n_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
      crst_q   <= crst_d;
      loaded_q <= loaded_d;
    end
  end

  assign o_imem_we   = we_q;
  assign o_imem_addr = addr_q;
  assign o_imem_data = data_q;
  assign o_stall     = stall_q;
  assign o_cpu_rst   = crst_q;
  assign o_loaded    = loaded_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: load, run/halt,
// step, command bytes as data, reset mid-load, full wrap.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_valid2 = 1'b0;

  logic        we, stall, crst, loaded;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        we2, stall2, crst2, loaded2;
  logic [1:0]  addr2;
  logic [31:0] data2;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] wa [16];
  logic [31:0] wd [16];
  int          wn = 0;
  logic [31:0] w2a [16];
  logic [31:0] w2d [16];
  int          w2n = 0;
  int          stall_low = 0;
  int          crst_low = 0;
  int          stall_pulses = 0;
  logic        prev_stall = 1'b1;

  always #5 clk = ~clk;

  instr_loader #(.SIZE(32), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_imem_we   (we),
    .o_imem_addr (addr),
    .o_imem_data (data),
    .o_stall     (stall),
    .o_cpu_rst   (crst),
    .o_loaded    (loaded)
  );

  instr_loader #(.SIZE(32), .ADDR_W(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid2),
    .o_imem_we   (we2),
    .o_imem_addr (addr2),
    .o_imem_data (data2),
    .o_stall     (stall2),
    .o_cpu_rst   (crst2),
    .o_loaded    (loaded2)
  );

  always @(negedge clk) begin
    if (we) begin
      if (wn < 16) begin
        wa[wn] <= 32'(addr);
        wd[wn] <= data;
      end
      wn <= wn + 1;
    end
    if (we2) begin
      if (w2n < 16) begin
        w2a[w2n] <= 32'(addr2);
        w2d[w2n] <= data2;
      end
      w2n <= w2n + 1;
    end
    if (!stall) stall_low <= stall_low + 1;
    if (!crst) crst_low <= crst_low + 1;
    if (!stall && prev_stall) stall_pulses <= stall_pulses + 1;
    prev_stall <= stall;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic stream(input logic [7:0] q[$]);
    foreach (q[i]) begin
      rx_data  = q[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_stall"}, 32'(stall), 32'd1);
    check({pfx, "_cpu_rst"}, 32'(crst), 32'd1);
    check({pfx, "_we"}, 32'(we), 32'd0);
    check({pfx, "_addr"}, 32'(addr), 32'd0);
    check({pfx, "_data"}, data, 32'd0);
    check({pfx, "_loaded"}, 32'(loaded), 32'd0);
  endtask

  initial begin
    int base;
    idle(2);
    rst = 1'b0;
    check_reset_vals("rst");

    // basic load
    stall_low = 0;
    crst_low  = 0;
    stream('{8'h4C, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
             8'h9A, 8'hBC, 8'hDE, 8'hF0});
    check("load_we_now", 32'(we), 32'd1);
    check("load_loaded_now", 32'(loaded), 32'd1);
    idle(2);
    check("load_nwr", 32'(wn), 32'd2);
    check("load_a0", wa[0], 32'd0);
    check("load_d0", wd[0], 32'h12345678);
    check("load_a1", wa[1], 32'd1);
    check("load_d1", wd[1], 32'h9ABCDEF0);
    check("load_loaded", 32'(loaded), 32'd1);
    check("load_stall_low", 32'(stall_low), 32'd0);
    check("load_crst_low", 32'(crst_low), 32'd0);

    // run / halt
    send(8'h52);
    check("run_stall", 32'(stall), 32'd0);
    check("run_cpu_rst", 32'(crst), 32'd0);
    idle(2);
    send(8'h48);
    check("halt_stall", 32'(stall), 32'd1);
    check("halt_cpu_rst", 32'(crst), 32'd0);

    // three single steps
    idle(1);
    stall_low    = 0;
    stall_pulses = 0;
    repeat (3) begin
      send(8'h53);
      idle(2);
    end
    check("step_low_cycles", 32'(stall_low), 32'd3);
    check("step_pulses", 32'(stall_pulses), 32'd3);
    check("step_cpu_rst", 32'(crst), 32'd0);

    // command codes as data, back-to-back
    base = wn;
    stall_low = 0;
    stream('{8'h4C, 8'h01, 8'h52, 8'h48, 8'h53, 8'h4C});
    idle(3);
    check("b2b_nwr", 32'(wn - base), 32'd1);
    check("b2b_addr", wa[base], 32'd0);
    check("b2b_data", wd[base], 32'h5248534C);
    check("b2b_stall_idle", 32'(stall), 32'd1);
    check("b2b_stall_low", 32'(stall_low), 32'd0);
    check("b2b_loaded", 32'(loaded), 32'd1);
    check("b2b_cpu_rst", 32'(crst), 32'd1);

    // 'L' while running
    send(8'h52);
    check("rl_run_stall", 32'(stall), 32'd0);
    send(8'h4C);
    check("rl_stall", 32'(stall), 32'd1);
    check("rl_cpu_rst", 32'(crst), 32'd1);
    check("rl_loaded_clr", 32'(loaded), 32'd0);
    base = wn;
    stream('{8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    idle(2);
    check("rl_nwr", 32'(wn - base), 32'd1);
    check("rl_data", wd[base], 32'h11223344);

    // reset mid-load
    base = wn;
    stream('{8'h4C, 8'h01, 8'h12, 8'h34});
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_vals("mid");
    idle(4);
    check("mid_nwr", 32'(wn - base), 32'd0);
    stream('{8'h4C, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    idle(2);
    check("mid_reload_nwr", 32'(wn - base), 32'd1);
    check("mid_reload_addr", wa[base], 32'd0);
    check("mid_reload_data", wd[base], 32'hAABBCCDD);

    // full load with wrap on the ADDR_W=2 instance
    rx_data   = 8'h4C;
    rx_valid2 = 1'b1;
    @(posedge clk);
    #1;
    rx_data = 8'h00;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 20; i++) begin
      rx_data = 8'(i);
      @(posedge clk);
      #1;
    end
    rx_valid2 = 1'b0;
    idle(3);
    check("wrap_nwr", 32'(w2n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_a%0d", k), w2a[k], 32'(k));
    end
    check("wrap_d0", w2d[0], 32'h01020304);
    check("wrap_d3", w2d[3], 32'h0D0E0F10);
    check("wrap_loaded", 32'(loaded2), 32'd1);
    check("wrap_stall", 32'(stall2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader and run controller that sits directly upstream of the `mips` core. It takes a byte stream from the UART receiver, decodes one-byte commands, and packs payload bytes into 32-bit instruction words written sequentially into instruction memory. It drives the core's `i_stall` and reset so the CPU stays frozen while loading and can then be run, halted or single-stepped.

## Interface
- `SIZE`, 32, instruction word width; must be a multiple of 8.
- `ADDR_W`, 8, instruction-memory word-address width.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid this cycle.
- `o_imem_we`  out  1  instruction-memory write enable, one-cycle pulse.
- `o_imem_addr`  out  ADDR_W  word address for the write.
- `o_imem_data`  out  SIZE  word to write.
- `o_stall`  out  1  drives `mips.i_stall`.
- `o_cpu_rst`  out  1  drives `mips.rst`.
- `o_loaded`  out  1  high once a complete load has finished.

## Operation
- Command codes:
  - `0x4C` 'L': load.
  - `0x52` 'R': run.
  - `0x48` 'H': halt.
  - `0x53` 'S': step.
  - Any other byte in IDLE/RUN is ignored.
- States: IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP.
- IDLE:
  - 'L' -> LOAD_CNT.
  - 'R' -> RUN.
  - 'S' -> STEP.
  - 'H' -> stay in IDLE.
- LOAD_CNT:
  - The next byte is the word count N.
  - N=0 means 2^ADDR_W words.
  - Clear the address and byte counters -> LOAD_DATA.
- LOAD_DATA:
  - Bytes are MSB-first, SIZE/8 bytes per word.
  - On the last byte of a word, register `o_imem_data` = {previous bytes, current byte}, set `o_imem_addr` = word counter, and pulse `o_imem_we`.
  - After the N-th word, set `o_loaded`=1 and go to IDLE.
  - Command codes arriving in this state are treated as data.
- RUN: 'H' -> IDLE; 'L' -> LOAD_CNT; all other bytes ignored.
- STEP: lasts one cycle, then returns to IDLE unconditionally.
- `o_stall` is 0 only in RUN and STEP; 1 in every other state.
- `o_cpu_rst`:
  - Goes to 1 on `rst` and on entry to LOAD_CNT.
  - Stays 1 through LOAD_DATA.
  - Clears on the first 'R' or 'S' accepted after that; stays 0 through halts.
- `o_loaded` clears on entry to LOAD_CNT.
- Address arithmetic: ADDR_W-bit counter; wraps modulo 2^ADDR_W, so N=0 fills addresses 0..2^ADDR_W-1 exactly.
- Byte counter: log2(SIZE/8) bits; wraps to 0 after each word.

## Timing
- Reset values (all registered):
  - state=IDLE, `o_stall`=1, `o_cpu_rst`=1.
  - `o_imem_we`=0, `o_imem_addr`=0, `o_imem_data`=0, `o_loaded`=0.
- State transition happens on the clock edge where `i_rx_valid`=1.
- Write latency: `o_imem_we` is high in the cycle after the edge that samples the last byte of a word, for exactly one cycle. Address and data are stable in that same cycle.
- No byte is dropped, including back-to-back `i_rx_valid` on consecutive cycles; there is no separate write state.
- `o_loaded` rises in the same cycle as the final `o_imem_we` pulse.
- `o_stall` falls in the cycle after the 'R'/'S' byte is sampled.
- STEP: `o_stall`=0 for exactly one cycle, so the core advances one clock.
- `o_cpu_rst` falls together with `o_stall` on the first run or step.
- `rst` mid-load: the partial word is discarded, no write is issued, and all outputs return to reset values on the next edge.
- 'L' while in RUN: `o_stall` and `o_cpu_rst` rise in the next cycle.

## Structure
- Shared package `mips_dbg_pkg` holds:
  - the command byte constants (CMD_LOAD, CMD_RUN, CMD_HALT, CMD_STEP);
  - the loader state enum.
- One natural sub-module: `word_packer`, a SIZE/8-byte MSB-first shift register with a byte counter that produces a word-complete strobe.
- The FSM and counters stay in `instr_loader`.

## Test plan
- **Basic load:** `rst`, then bytes 4C 02 12 34 56 78 9A BC DE F0.
  - Expect writes addr0=0x12345678 and addr1=0x9ABCDEF0, one cycle each.
  - `o_loaded`=1; `o_stall`=1 and `o_cpu_rst`=1 throughout.
- **Run/halt:** after the load, send 52.
  - `o_stall`=0 and `o_cpu_rst`=0 the next cycle.
  - Then 48 -> `o_stall`=1 the next cycle, `o_cpu_rst` stays 0.
- **Step:** from IDLE send 53 three times.
  - Three isolated one-cycle `o_stall`=0 pulses.
- **Data containing command codes, back-to-back:** 4C 01 52 48 53 4C on consecutive cycles.
  - One write, addr0=0x5248534C; state returns to IDLE, not RUN.
- **Full/wrap:** ADDR_W=2, count byte 00, 16 bytes.
  - Writes to addresses 0,1,2,3 in order; a 5th write never occurs.
- **Reset mid-load:** `rst` after 4C 01 12 34.
  - No write; all outputs at reset values.
  - A following 4C 01 AA BB CC DD writes addr0=0xAABBCCDD.
